pe_array_scheduler: RTL and testbench
=====================================

Name: pe_array_scheduler

Overview:
Sequences an array of NUM_PE processing elements through the full background-removal flow: broadcast sum phase, collection of per-PE channel sums, computation of the expected background colour (mean RGB), broadcast background-removal phase, and per-phase Ack release. It sits between the host/top-level control and the PE array. It owns every PE Start/Ack strobe and drives the shared red_exp/green_exp/blue_exp bus.

Parameters:
NUM_PE, 4, number of processing elements controlled (>=1)
PIXELS_PER_PE, 1, pixels per PE; NUM_PE*PIXELS_PER_PE must be a power of two
SUM_W, 8*PIXELS_PER_PE, width of each PE per-channel sum
TIMEOUT, 1024, max cycles to wait for any PE phase completion

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Start  in  1  one-cycle pulse from host; begins a run
Use_Host_Exp  in  1  sampled with Start; 1 = skip sum phase, use host_r/g/b
host_r, host_g, host_b  in  8 each  host-supplied expected colour
pe_qi  in  NUM_PE  PE idle flags
pe_qsd  in  NUM_PE  PE sum-done flags
pe_qbgd  in  NUM_PE  PE bg-done flags
red_sum_bus, green_sum_bus, blue_sum_bus  in  SUM_W*NUM_PE each  PE k sum at [k*SUM_W +: SUM_W]
Start_Sum  out  1  broadcast to all PEs
Start_BgRemoval  out  1  broadcast to all PEs
Ack  out  1  broadcast to all PEs
red_exp, green_exp, blue_exp  out  8 each  expected background colour to PEs
Busy  out  1  high from the cycle after Start until Done/Error
Done  out  1  one-cycle pulse on successful completion
Error  out  1  sticky until next accepted Start; timeout occurred

Behaviour:
- Reset low: state IDLE. All strobes, Busy, Done and Error are 0. exp outputs are 0. Accumulators and counters are 0.
- States: IDLE, SUM_GO, SUM_WAIT, SUM_COLLECT, SUM_ACK, SUM_REL, AVG, BG_GO, BG_WAIT, BG_ACK, BG_REL, FINISH, ERR.
- IDLE: Start=1 and &pe_qi=1 -> sample Use_Host_Exp. If 1, load exp from host_* and go to BG_GO; else go to SUM_GO. Start is ignored when any PE is not idle or when the block is not in IDLE.
- SUM_GO: Start_Sum=1 for exactly one cycle -> SUM_WAIT. Clear accumulators and the timeout counter.
- SUM_WAIT: wait for &pe_qsd -> SUM_COLLECT. pe_qsd bits may rise in different cycles; only the AND counts.
- SUM_COLLECT: one PE per cycle, index 0..NUM_PE-1. Add PE k's three sums into the accumulators. Accumulator width is SUM_W+clog2(NUM_PE)+1 with no overflow loss. Takes NUM_PE cycles -> SUM_ACK.
- SUM_ACK: Ack=1 for one cycle -> SUM_REL.
- SUM_REL: wait for &pe_qi -> AVG.
- AVG: exp = accumulator >> log2(NUM_PE*PIXELS_PER_PE), saturated to 255 if the result exceeds 8 bits. Registered outputs become valid the cycle after AVG and are held stable through BG_WAIT -> BG_GO.
- BG_GO: Start_BgRemoval=1 for one cycle -> BG_WAIT.
- BG_WAIT: wait for &pe_qbgd -> BG_ACK.
- BG_ACK: Ack=1 for one cycle -> BG_REL.
- BG_REL: wait for &pe_qi -> FINISH.
- FINISH: Done=1 for one cycle -> IDLE. exp outputs keep their last value.
- Timeout: a counter runs in SUM_WAIT, SUM_REL, BG_WAIT and BG_REL, reset on entry to each. If it reaches TIMEOUT, go to ERR. ERR sets Error=1 and pulses Ack once to free the PEs, then -> IDLE.
- Error is cleared on the next accepted Start. Busy=0 in IDLE.
- Start_Sum, Start_BgRemoval and Ack are mutually exclusive and never high for two consecutive cycles.
- Start received while Busy: ignored, with no effect on state.
- Reset asserted mid-run: immediate return to IDLE with all outputs at reset values. The PEs are reset by the same reset net.

Test Plan:
- NUM_PE=4, Use_Host_Exp=0, red sums 10,20,30,40, green all 64, blue 255 each, all qsd after 3 cycles -> one Start_Sum pulse; exp = 25/64/255; one Ack per phase; Done 1 cycle after final &pe_qi.
- Sums 255 in all PEs with PIXELS_PER_PE=1 -> total 1020, exp=255; no wrap.
- Use_Host_Exp=1, host=(0,200,0) -> no Start_Sum; exp=(0,200,0) before Start_BgRemoval; Done asserted.
- pe_qsd bits rise at cycles 2,5,9,4 -> SUM_COLLECT entered only after cycle 9; Start pulse during Busy ignored.
- PE 2 never raises qbgd, TIMEOUT=16 -> ERR after 16 cycles in BG_WAIT; Error=1, one Ack pulse, IDLE; next Start clears Error.
- Reset low during SUM_COLLECT -> all outputs 0 next evaluation; after release, a new Start runs cleanly from 0 accumulators.

Source files
------------

// File: rtl/pe_array_scheduler.sv
// Sequences a PE array through sum, average, background-removal and Ack release phases,
// driving the shared expected-colour bus and all PE strobes.
module pe_array_scheduler #(
  parameter int NUM_PE        = 4,
  parameter int PIXELS_PER_PE = 1,
  parameter int SUM_W         = 8 * PIXELS_PER_PE,
  parameter int TIMEOUT       = 1024
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Use_Host_Exp,
  input  logic [7:0]                host_r,
  input  logic [7:0]                host_g,
  input  logic [7:0]                host_b,
  input  logic [NUM_PE-1:0]         pe_qi,
  input  logic [NUM_PE-1:0]         pe_qsd,
  input  logic [NUM_PE-1:0]         pe_qbgd,
  input  logic [SUM_W*NUM_PE-1:0]   red_sum_bus,
  input  logic [SUM_W*NUM_PE-1:0]   green_sum_bus,
  input  logic [SUM_W*NUM_PE-1:0]   blue_sum_bus,
  output logic                      Start_Sum,
  output logic                      Start_BgRemoval,
  output logic                      Ack,
  output logic [7:0]                red_exp,
  output logic [7:0]                green_exp,
  output logic [7:0]                blue_exp,
  output logic                      Busy,
  output logic                      Done,
  output logic                      Error
);

  localparam int ACC_W = SUM_W + $clog2(NUM_PE) + 1;
  localparam int SHIFT = $clog2(NUM_PE * PIXELS_PER_PE);
  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, SUM_GO, SUM_WAIT, SUM_COLLECT, SUM_ACK, SUM_REL, AVG,
    BG_GO, BG_WAIT, BG_ACK, BG_REL, FINISH, ERR
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] red_acc, green_acc, blue_acc;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic             timed_out;

  logic [SUM_W-1:0] red_sum   [NUM_PE];
  logic [SUM_W-1:0] green_sum [NUM_PE];
  logic [SUM_W-1:0] blue_sum  [NUM_PE];

  for (genvar k = 0; k < NUM_PE; k++) begin : g_slice
    assign red_sum[k]   = red_sum_bus[k*SUM_W +: SUM_W];
    assign green_sum[k] = green_sum_bus[k*SUM_W +: SUM_W];
    assign blue_sum[k]  = blue_sum_bus[k*SUM_W +: SUM_W];
  end

  assign timed_out = (cnt == CNT_LAST);

  // Mean over all pixels of the array, clipped to the 8-bit colour range.
  function automatic logic [7:0] avg_sat(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] q;
    q = acc >> SHIFT;
    if (q > ACC_W'(255)) return 8'hFF;
    return q[7:0];
  endfunction

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      Ack             <= 1'b0;
      Busy            <= 1'b0;
      Done            <= 1'b0;
      Error           <= 1'b0;
      red_exp         <= '0;
      green_exp       <= '0;
      blue_exp        <= '0;
      red_acc         <= '0;
      green_acc       <= '0;
      blue_acc        <= '0;
      idx             <= '0;
      cnt             <= '0;
    end else begin
      Start_Sum       <= 1'b0;
      Start_BgRemoval <= 1'b0;
      Ack             <= 1'b0;
      Done            <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && (&pe_qi)) begin
            Busy  <= 1'b1;
            Error <= 1'b0;
            if (Use_Host_Exp) begin
              red_exp         <= host_r;
              green_exp       <= host_g;
              blue_exp        <= host_b;
              Start_BgRemoval <= 1'b1;
              state           <= BG_GO;
            end else begin
              Start_Sum <= 1'b1;
              state     <= SUM_GO;
            end
          end
        end
        SUM_GO: begin
          red_acc   <= '0;
          green_acc <= '0;
          blue_acc  <= '0;
          idx       <= '0;
          cnt       <= '0;
          state     <= SUM_WAIT;
        end
        SUM_WAIT: begin
          if (&pe_qsd) begin
            state <= SUM_COLLECT;
          end else if (timed_out) begin
            Error <= 1'b1;
            Ack   <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SUM_COLLECT: begin
          red_acc   <= red_acc   + ACC_W'(red_sum[idx]);
          green_acc <= green_acc + ACC_W'(green_sum[idx]);
          blue_acc  <= blue_acc  + ACC_W'(blue_sum[idx]);
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            Ack   <= 1'b1;
            state <= SUM_ACK;
          end
        end
        SUM_ACK: begin
          cnt   <= '0;
          state <= SUM_REL;
        end
        SUM_REL: begin
          if (&pe_qi) begin
            state <= AVG;
          end else if (timed_out) begin
            Error <= 1'b1;
            Ack   <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        AVG: begin
          red_exp         <= avg_sat(red_acc);
          green_exp       <= avg_sat(green_acc);
          blue_exp        <= avg_sat(blue_acc);
          Start_BgRemoval <= 1'b1;
          state           <= BG_GO;
        end
        BG_GO: begin
          cnt   <= '0;
          state <= BG_WAIT;
        end
        BG_WAIT: begin
          if (&pe_qbgd) begin
            Ack   <= 1'b1;
            state <= BG_ACK;
          end else if (timed_out) begin
            Error <= 1'b1;
            Ack   <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BG_ACK: begin
          cnt   <= '0;
          state <= BG_REL;
        end
        BG_REL: begin
          if (&pe_qi) begin
            Done  <= 1'b1;
            state <= FINISH;
          end else if (timed_out) begin
            Error <= 1'b1;
            Ack   <= 1'b1;
            state <= ERR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FINISH: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        ERR: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_scheduler.sv
// Randomized directed bench: a cycle-stepped PE array model answers the scheduler's strobes
// while a plain-arithmetic reference predicts colours, pulse counts and latencies.
module tb_pe_array_scheduler;

  localparam int NPE = 4;
  localparam int SW  = 8;
  localparam int TMO = 16;

  logic              Clk = 1'b0;
  logic              Reset = 1'b0;
  logic              Start = 1'b0;
  logic              Use_Host_Exp = 1'b0;
  logic [7:0]        host_r = '0, host_g = '0, host_b = '0;
  logic [NPE-1:0]    pe_qi = '1, pe_qsd = '0, pe_qbgd = '0;
  logic [SW*NPE-1:0] red_sum_bus = '0, green_sum_bus = '0, blue_sum_bus = '0;
  logic              Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error;
  logic [7:0]        red_exp, green_exp, blue_exp;

  pe_array_scheduler #(
    .NUM_PE(NPE), .PIXELS_PER_PE(1), .SUM_W(SW), .TIMEOUT(TMO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Use_Host_Exp(Use_Host_Exp),
    .host_r(host_r), .host_g(host_g), .host_b(host_b),
    .pe_qi(pe_qi), .pe_qsd(pe_qsd), .pe_qbgd(pe_qbgd),
    .red_sum_bus(red_sum_bus), .green_sum_bus(green_sum_bus), .blue_sum_bus(blue_sum_bus),
    .Start_Sum(Start_Sum), .Start_BgRemoval(Start_BgRemoval), .Ack(Ack),
    .red_exp(red_exp), .green_exp(green_exp), .blue_exp(blue_exp),
    .Busy(Busy), .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int sr[NPE], sg[NPE], sb[NPE], dq[NPE], db[NPE];

  task automatic tick;
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic randomize_pes;
    for (int k = 0; k < NPE; k++) begin
      sr[k] = int'($urandom_range(0, 255));
      sg[k] = int'($urandom_range(0, 255));
      sb[k] = int'($urandom_range(0, 255));
      dq[k] = int'($urandom_range(1, 12));
      db[k] = int'($urandom_range(1, 12));
    end
  endtask

  task automatic run(input bit use_host, input logic [7:0] hr, input logic [7:0] hg,
                     input logic [7:0] hb, input int stuck, input bit poke, input bit rst_mid);
    int tr, tg, tb, maxdq;
    int mode, prev_mode, t0, rel, lastq, qi_up, bg_cyc;
    int n_ss, n_bg, n_ack, n_done, viol, bad_exp;
    bit finished, aborted, err_seen, in_bg, pss, pbg, pack;
    logic [23:0] eexp;

    tr = 0; tg = 0; tb = 0; maxdq = 0;
    for (int k = 0; k < NPE; k++) begin
      tr += sr[k]; tg += sg[k]; tb += sb[k];
      if (dq[k] > maxdq) maxdq = dq[k];
      red_sum_bus[k*SW +: SW]   = 8'(sr[k]);
      green_sum_bus[k*SW +: SW] = 8'(sg[k]);
      blue_sum_bus[k*SW +: SW]  = 8'(sb[k]);
    end
    if (use_host) eexp = {hr, hg, hb};
    else eexp = {8'((tr / NPE > 255) ? 255 : tr / NPE),
                 8'((tg / NPE > 255) ? 255 : tg / NPE),
                 8'((tb / NPE > 255) ? 255 : tb / NPE)};

    mode = 0; prev_mode = 0; t0 = 0; rel = 1; lastq = -100; qi_up = -100; bg_cyc = -100;
    n_ss = 0; n_bg = 0; n_ack = 0; n_done = 0; viol = 0; bad_exp = 0;
    finished = 0; aborted = 0; err_seen = 0; in_bg = 0; pss = 0; pbg = 0; pack = 0;

    pe_qi = '1; pe_qsd = '0; pe_qbgd = '0;
    Use_Host_Exp = use_host; host_r = hr; host_g = hg; host_b = hb;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    check("busy_after_start", 32'(Busy), 32'd1);
    check("error_cleared_on_start", 32'(Error), 32'd0);

    for (int c = 0; c < 400 && !finished; c++) begin
      if (int'(Start_Sum) + int'(Start_BgRemoval) + int'(Ack) > 1) viol++;
      if ((Start_Sum && pss) || (Start_BgRemoval && pbg) || (Ack && pack)) viol++;
      pss = Start_Sum; pbg = Start_BgRemoval; pack = Ack;
      if (in_bg && {red_exp, green_exp, blue_exp} !== eexp) bad_exp++;
      if (Start_Sum) begin
        n_ss++; mode = 1; t0 = cyc; lastq = cyc + maxdq;
      end
      if (Start_BgRemoval) begin
        n_bg++; in_bg = 1; bg_cyc = cyc; mode = 2; t0 = cyc;
        check("exp_at_bg_start", 32'({red_exp, green_exp, blue_exp}), 32'(eexp));
      end
      if (Ack) begin
        n_ack++;
        if (mode == 1) check("sum_ack_latency", cyc, lastq + NPE + 1);
        prev_mode = mode; mode = 3; t0 = cyc; rel = int'($urandom_range(1, 3));
        pe_qsd = '0; pe_qbgd = '0;
      end
      if (Done) begin
        n_done++; finished = 1;
        check("done_latency", cyc, qi_up + 1);
      end
      if (Error && !err_seen) begin
        err_seen = 1; finished = 1;
        check("timeout_latency", cyc, bg_cyc + TMO + 1);
        check("err_ack_pulse", 32'(Ack), 32'd1);
      end

      Start = 1'b0;
      if (rst_mid && mode == 1 && cyc == lastq + 2) begin
        Reset = 1'b0;
        #1;
        check("reset_mid_outputs",
              32'({Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error, red_exp, green_exp, blue_exp}),
              32'd0);
        pe_qi = '1; pe_qsd = '0; pe_qbgd = '0;
        aborted = 1; finished = 1;
      end else begin
        case (mode)
          1: for (int k = 0; k < NPE; k++) if (cyc >= t0 + dq[k]) pe_qsd[k] = 1'b1;
          2: for (int k = 0; k < NPE; k++) if (k != stuck && cyc >= t0 + db[k]) pe_qbgd[k] = 1'b1;
          3: if (cyc >= t0 + rel) begin
               pe_qi = '1; qi_up = cyc; mode = 0;
               if (poke && prev_mode == 1) Start = 1'b1;
             end
          default: ;
        endcase
        if (Start_Sum || Start_BgRemoval) pe_qi = '0;
        if (Done && poke) Start = 1'b1;
      end
      tick;
    end

    Start = 1'b0;
    check("run_within_bound", 32'(finished), 32'd1);
    if (aborted) begin
      Reset = 1'b1;
      tick;
      check("idle_after_reset", 32'({Busy, Error, Done, Ack}), 32'd0);
    end else begin
      pe_qi = '1; pe_qsd = '0; pe_qbgd = '0;
      check("start_sum_pulses", n_ss, use_host ? 0 : 1);
      check("bg_start_pulses", n_bg, 1);
      check("ack_pulses", n_ack, use_host ? 1 : 2);
      check("done_pulses", n_done, (stuck >= 0) ? 0 : 1);
      check("strobe_rules", viol, 0);
      check("exp_held_stable", bad_exp, 0);
      check("idle_busy", 32'(Busy), 32'd0);
      check("idle_ack", 32'(Ack), 32'd0);
      check("error_flag", 32'(Error), (stuck >= 0) ? 32'd1 : 32'd0);
      check("exp_kept", 32'({red_exp, green_exp, blue_exp}), 32'(eexp));
      tick;
      check("no_restart", 32'({Busy, Start_Sum, Start_BgRemoval}), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0;
    tick;
    tick;
    check("reset_outputs",
          32'({Start_Sum, Start_BgRemoval, Ack, Busy, Done, Error, red_exp, green_exp, blue_exp}),
          32'd0);
    Reset = 1'b1;
    tick;

    pe_qi = 4'b1011; Start = 1'b1;
    tick;
    Start = 1'b0; pe_qi = '1;
    check("start_ignored_pe_busy", 32'({Busy, Start_Sum, Start_BgRemoval}), 32'd0);

    randomize_pes;
    sr = '{10, 20, 30, 40}; sg = '{64, 64, 64, 64}; sb = '{255, 255, 255, 255};
    dq = '{3, 3, 3, 3};
    run(1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 1'b0);

    randomize_pes;
    sr = '{255, 255, 255, 255}; sg = '{255, 255, 255, 255}; sb = '{255, 255, 255, 255};
    run(1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 1'b0);

    randomize_pes;
    run(1'b1, 8'd0, 8'd200, 8'd0, -1, 1'b0, 1'b0);

    randomize_pes;
    dq = '{2, 5, 9, 4};
    run(1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b1, 1'b0);

    randomize_pes;
    run(1'b0, 8'd0, 8'd0, 8'd0, 2, 1'b0, 1'b0);

    randomize_pes;
    run(1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 1'b0);

    randomize_pes;
    run(1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0, 1'b1);

    randomize_pes;
    run(1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      randomize_pes;
      run(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom), -1, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
